// File: rtl/uart_delay_cfg_sched.sv
// uart_delay_cfg_sched
//   Round-robin scheduler sharing one UART delay-configuration link between
//   four DAC-port requesters. Each request latches a 24-bit delay as pending;
//   the scheduler formats one 64-bit configuration word at a time and drives
//   the UART_TX_DATA data/valid/ready handshake.
//
// Ports
//   I_clk_10M     : single 10 MHz clock
//   I_rst_n       : asynchronous active-low reset
//   I_awg_id      : AWG ID placed in the frame, sampled at grant
//   I_req[3:0]    : per-port request strobe (bit i = port i+1)
//   I_delay_p1..4 : per-port delay, sampled with the matching I_req bit
//   I_tx_ready    : UART_TX_DATA idle / able to accept
//   O_data        : {HEADER, awg_id, port, delay}
//   O_data_valid  : frame valid, held until accepted
//   O_ack[3:0]    : one-cycle pulse on the port whose frame was accepted
//   O_err         : one-cycle pulse when a frame is abandoned on timeout
//   O_busy        : high whenever the scheduler is not idle
//   O_pending[3:0]: per-port pending flags
module uart_delay_cfg_sched #(
   parameter logic [31:0] HEADER      = 32'h02002000,
   parameter int unsigned GAP_CYC     = 16,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic        I_clk_10M,
   input  logic        I_rst_n,
   input  logic [3:0]  I_awg_id,
   input  logic [3:0]  I_req,
   input  logic [23:0] I_delay_p1,
   input  logic [23:0] I_delay_p2,
   input  logic [23:0] I_delay_p3,
   input  logic [23:0] I_delay_p4,
   input  logic        I_tx_ready,
   output logic [63:0] O_data,
   output logic        O_data_valid,
   output logic [3:0]  O_ack,
   output logic        O_err,
   output logic        O_busy,
   output logic [3:0]  O_pending
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_GAP       = 3'd4
   } state_t;

   localparam logic [7:0] GAP_LAST = 8'(GAP_CYC - 1);
   localparam logic [9:0] TO_LAST  = 10'(TIMEOUT_CYC - 1);

   state_t      state_q, state_d;
   logic [3:0]  pending_q, pending_d;
   logic [23:0] delay_q [4];
   logic [23:0] delay_d [4];
   logic [23:0] delay_in [4];
   logic [1:0]  last_grant_q, last_grant_d;
   logic [63:0] data_q, data_d;
   logic        valid_q, valid_d;
   logic [3:0]  ack_q, ack_d;
   logic        err_q, err_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic [9:0]  to_cnt_q, to_cnt_d;

   logic        win_vld;
   logic [1:0]  win_idx;
   logic [3:0]  port_num;
   logic [3:0]  grant_mask;
   logic [3:0]  pend_clr;
   logic [3:0]  pend_set;

   // Round-robin pick: search starts one past the last grant and wraps.
   // Returns {found, index}.
   function automatic logic [2:0] rr_pick(input logic [3:0] pend,
                                          input logic [1:0] last);
      logic [2:0] res;
      logic [1:0] idx;
      res = 3'b000;
      for (int k = 1; k <= 4; k++) begin
         idx = last + 2'(k);
         if (!res[2] && pend[idx]) begin
            res = {1'b1, idx};
         end
      end
      return res;
   endfunction

   assign delay_in[0] = I_delay_p1;
   assign delay_in[1] = I_delay_p2;
   assign delay_in[2] = I_delay_p3;
   assign delay_in[3] = I_delay_p4;

   assign {win_vld, win_idx} = rr_pick(pending_q, last_grant_q);
   assign port_num           = {2'b00, win_idx} + 4'd1;
   assign grant_mask         = 4'b0001 << last_grant_q;

   // State register
   always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (win_vld) state_d = ST_SEND;
         ST_SEND:      if (I_tx_ready) state_d = ST_WAIT_BUSY;
         ST_WAIT_BUSY: begin
            if (!I_tx_ready) begin
               state_d = ST_WAIT_DONE;
            end else if (to_cnt_q == TO_LAST) begin
               state_d = ST_GAP;
            end
         end
         ST_WAIT_DONE: if (I_tx_ready) state_d = ST_GAP;
         ST_GAP:       if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Output / datapath logic
   always_comb begin
      data_d       = data_q;
      valid_d      = valid_q;
      ack_d        = 4'b0000;
      err_d        = 1'b0;
      last_grant_d = last_grant_q;
      gap_cnt_d    = gap_cnt_q;
      to_cnt_d     = to_cnt_q;
      pend_clr     = 4'b0000;
      pend_set     = 4'b0000;

      case (state_q)
         ST_IDLE: begin
            if (win_vld) begin
               data_d       = {HEADER, I_awg_id, port_num, delay_q[win_idx]};
               valid_d      = 1'b1;
               last_grant_d = win_idx;
            end
         end
         ST_SEND: begin
            if (I_tx_ready) begin
               valid_d  = 1'b0;
               ack_d    = grant_mask;
               pend_clr = grant_mask;
               to_cnt_d = 10'd0;
            end
         end
         ST_WAIT_BUSY: begin
            // The UART never went busy: give up and requeue the port so the
            // frame is retried later with whatever delay it holds by then.
            if (I_tx_ready) begin
               if (to_cnt_q == TO_LAST) begin
                  err_d     = 1'b1;
                  pend_set  = grant_mask;
                  gap_cnt_d = 8'd0;
               end else begin
                  to_cnt_d = to_cnt_q + 10'd1;
               end
            end
         end
         ST_WAIT_DONE: begin
            if (I_tx_ready) gap_cnt_d = 8'd0;
         end
         ST_GAP: begin
            if (gap_cnt_q != GAP_LAST) gap_cnt_d = gap_cnt_q + 8'd1;
         end
         default: ;
      endcase

      // A new request on the accept edge wins over the clear.
      pending_d = (pending_q & ~pend_clr) | pend_set | I_req;
      for (int i = 0; i < 4; i++) begin
         delay_d[i] = I_req[i] ? delay_in[i] : delay_q[i];
      end
   end

   // Datapath registers
   always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
      if (!I_rst_n) begin
         pending_q    <= 4'b0000;
         last_grant_q <= 2'd3;
         data_q       <= 64'd0;
         valid_q      <= 1'b0;
         ack_q        <= 4'b0000;
         err_q        <= 1'b0;
         gap_cnt_q    <= 8'd0;
         to_cnt_q     <= 10'd0;
         for (int i = 0; i < 4; i++) begin
            delay_q[i] <= 24'd0;
         end
      end else begin
         pending_q    <= pending_d;
         last_grant_q <= last_grant_d;
         data_q       <= data_d;
         valid_q      <= valid_d;
         ack_q        <= ack_d;
         err_q        <= err_d;
         gap_cnt_q    <= gap_cnt_d;
         to_cnt_q     <= to_cnt_d;
         for (int i = 0; i < 4; i++) begin
            delay_q[i] <= delay_d[i];
         end
      end
   end

   assign O_data       = data_q;
   assign O_data_valid = valid_q;
   assign O_ack        = ack_q;
   assign O_err        = err_q;
   assign O_busy       = (state_q != ST_IDLE);
   assign O_pending    = pending_q;

endmodule

// File: tb/tb_uart_delay_cfg_sched.sv
// Directed bench for uart_delay_cfg_sched (default parameters).
module tb_uart_delay_cfg_sched;

   logic        clk;
   logic        rst_n;
   logic [3:0]  awg_id;
   logic [3:0]  req;
   logic [23:0] d1, d2, d3, d4;
   logic        tx_ready;
   logic [63:0] o_data;
   logic        o_valid;
   logic [3:0]  o_ack;
   logic        o_err;
   logic        o_busy;
   logic [3:0]  o_pending;

   int vectors;
   int miscompares;

   uart_delay_cfg_sched dut (
      .I_clk_10M   (clk),
      .I_rst_n     (rst_n),
      .I_awg_id    (awg_id),
      .I_req       (req),
      .I_delay_p1  (d1),
      .I_delay_p2  (d2),
      .I_delay_p3  (d3),
      .I_delay_p4  (d4),
      .I_tx_ready  (tx_ready),
      .O_data      (o_data),
      .O_data_valid(o_valid),
      .O_ack       (o_ack),
      .O_err       (o_err),
      .O_busy      (o_busy),
      .O_pending   (o_pending)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Expected frame for AWG 14
   function automatic logic [63:0] word(input logic [3:0] port, input logic [23:0] dly);
      return {32'h02002000, 4'he, port, dly};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Wait for a frame, check it, accept it, run the UART busy/done handshake
   // and measure the idle gap before the scheduler returns to idle.
   task automatic serve(input string tag, input logic [3:0] ack_exp, input logic [63:0] data_exp,
                        input logic [3:0] req_acc, input logic [3:0] req_ack,
                        input logic [3:0] pend_exp);
      int n;
      n = 0;
      while (o_valid !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, o_valid, 1'b1);
      check({tag, "_data"}, o_data, data_exp);
      tx_ready = 1'b1;
      req = req_acc;
      tick();                       // accept edge
      req = 4'b0000;
      check({tag, "_ack"}, o_ack, ack_exp);
      check({tag, "_valid_drop"}, o_valid, 1'b0);
      check({tag, "_pend"}, o_pending, pend_exp);
      req = req_ack;
      tx_ready = 1'b0;
      tick();                       // UART goes busy
      req = 4'b0000;
      check({tag, "_ack_pulse"}, o_ack, 4'b0000);
      tick();
      tx_ready = 1'b1;
      tick();                       // UART done -> gap starts
      n = 0;
      while (o_busy === 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check({tag, "_gap"}, n, 16);
   endtask

   initial begin
      int n;
      int bad;
      logic seen;
      vectors     = 0;
      miscompares = 0;
      rst_n    = 1'b0;
      awg_id   = 4'd14;
      req      = 4'b0000;
      d1 = 24'd0; d2 = 24'd0; d3 = 24'd0; d4 = 24'd0;
      tx_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_data", o_data, 64'd0);
      check("rst_valid", o_valid, 1'b0);
      check("rst_ack", o_ack, 4'b0000);
      check("rst_err", o_err, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_pend", o_pending, 4'b0000);
      rst_n = 1'b1;
      tick();

      // Single request: valid two edges after the request
      d1  = 24'h00000a;
      req = 4'b0001;
      tick();
      req = 4'b0000;
      check("single_pend", o_pending, 4'b0001);
      check("single_novalid", o_valid, 1'b0);
      tick();
      check("single_valid", o_valid, 1'b1);
      check("single_busy", o_busy, 1'b1);
      check("single_data", o_data, 64'h02002000_e_1_00000a);
      tick();
      tick();
      check("single_hold", o_valid, 1'b1);
      serve("single", 4'b0001, 64'h02002000_e_1_00000a, 4'b0000, 4'b0000, 4'b0000);

      // Simultaneous requests from reset: ports 1..4 in order
      do_reset();
      tx_ready = 1'b1;
      d1 = 24'd10; d2 = 24'd20; d3 = 24'd30; d4 = 24'd40;
      req = 4'b1111;
      tick();
      req = 4'b0000;
      serve("all_p1", 4'b0001, 64'h02002000_e_1_00000a, 4'b0000, 4'b0000, 4'b1110);
      serve("all_p2", 4'b0010, 64'h02002000_e_2_000014, 4'b0000, 4'b0000, 4'b1100);
      serve("all_p3", 4'b0100, 64'h02002000_e_3_00001e, 4'b0000, 4'b0000, 4'b1000);
      serve("all_p4", 4'b1000, 64'h02002000_e_4_000028, 4'b0000, 4'b0000, 4'b0000);

      // Fairness: ports 1 and 3 keep re-requesting, grants alternate
      do_reset();
      tx_ready = 1'b1;
      d1 = 24'd1; d3 = 24'd3;
      req = 4'b0101;
      tick();
      req = 4'b0000;
      serve("fair1", 4'b0001, word(4'd1, 24'd1), 4'b0000, 4'b0001, 4'b0100);
      serve("fair2", 4'b0100, word(4'd3, 24'd3), 4'b0000, 4'b0100, 4'b0001);
      serve("fair3", 4'b0001, word(4'd1, 24'd1), 4'b0000, 4'b0001, 4'b0100);
      serve("fair4", 4'b0100, word(4'd3, 24'd3), 4'b0000, 4'b0000, 4'b0001);
      serve("fair5", 4'b0001, word(4'd1, 24'd1), 4'b0000, 4'b0000, 4'b0000);

      // Coalescing: port 2 requested twice while port 1 is in SEND
      do_reset();
      tx_ready = 1'b0;
      d1  = 24'd5;
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      check("coal_send", o_valid, 1'b1);
      d2  = 24'h000014;
      req = 4'b0010;
      tick();
      d2  = 24'h000063;
      tick();
      req = 4'b0000;
      check("coal_pend", o_pending, 4'b0011);
      serve("coal_p1", 4'b0001, word(4'd1, 24'd5), 4'b0000, 4'b0000, 4'b0010);
      serve("coal_p2", 4'b0010, word(4'd2, 24'h000063), 4'b0000, 4'b0000, 4'b0000);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (o_valid !== 1'b0) seen = 1'b1;
      end
      check("coal_single_frame", seen, 1'b0);

      // Collision: new request for port 3 on its own accept edge
      d3  = 24'd7;
      req = 4'b0100;
      tick();
      req = 4'b0000;
      d3  = 24'd8;
      serve("coll1", 4'b0100, word(4'd3, 24'd7), 4'b0100, 4'b0000, 4'b0100);
      serve("coll2", 4'b0100, word(4'd3, 24'd8), 4'b0000, 4'b0000, 4'b0000);

      // Timeout: UART never goes busy after accept
      d4  = 24'h000044;
      req = 4'b1000;
      tick();
      req = 4'b0000;
      n = 0;
      while (o_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("to_data", o_data, word(4'd4, 24'h000044));
      tick();                       // accept edge (ready held high)
      check("to_ack", o_ack, 4'b1000);
      check("to_pend_clr", o_pending, 4'b0000);
      seen = 1'b0;
      for (int i = 0; i < 63; i++) begin
         tick();
         if (o_err !== 1'b0) seen = 1'b1;
      end
      check("to_early_err", seen, 1'b0);
      tick();
      check("to_err", o_err, 1'b1);
      check("to_pend_set", o_pending, 4'b1000);
      tick();
      check("to_err_pulse", o_err, 1'b0);
      serve("to_retry", 4'b1000, word(4'd4, 24'h000044), 4'b0000, 4'b0000, 4'b0000);

      // Backpressure in SEND, then reset mid-SEND
      tx_ready = 1'b0;
      d1  = 24'h000055;
      req = 4'b0001;
      tick();
      req = 4'b0000;
      tick();
      check("bp_valid", o_valid, 1'b1);
      check("bp_data", o_data, word(4'd1, 24'h000055));
      d2  = 24'h000022;
      req = 4'b0010;
      tick();
      req = 4'b0000;
      bad = 0;
      for (int i = 0; i < 500; i++) begin
         tick();
         if (o_valid !== 1'b1 || o_data !== word(4'd1, 24'h000055)) bad++;
      end
      check("bp_stable", bad, 0);
      check("bp_pend", o_pending, 4'b0011);
      #20;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", o_valid, 1'b0);
      check("mid_rst_data", o_data, 64'd0);
      check("mid_rst_ack", o_ack, 4'b0000);
      check("mid_rst_err", o_err, 1'b0);
      check("mid_rst_busy", o_busy, 1'b0);
      check("mid_rst_pend", o_pending, 4'b0000);
      tick();
      rst_n    = 1'b1;
      tx_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (o_valid !== 1'b0) seen = 1'b1;
      end
      check("post_rst_idle", seen, 1'b0);
      check("post_rst_pend", o_pending, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_delay_cfg_sched.md
# uart_delay_cfg_sched

Round-robin scheduler that shares the single host-side UART delay-configuration link between four DAC-port configuration requesters. Each requester posts a 24-bit delay for its port. The block latches it as pending, formats the 64-bit configuration word, and drives the `UART_TX_DATA` data/valid/ready handshake one frame at a time. It sits between host control logic and `UART_TX_DATA` in the 10 MHz UART domain.

## Interface
Parameters:
- `HEADER`, default `32'h02002000`: constant placed in `O_data[63:32]`.
- `GAP_CYC`, default 16: idle cycles enforced after a frame completes, before the next grant (range 1..255).
- `TIMEOUT_CYC`, default 64: maximum cycles in WAIT_BUSY before the frame is abandoned (range 1..1023).

Ports:
- `I_clk_10M` in 1: the block's single clock.
- `I_rst_n` in 1: asynchronous, active-low reset.
- `I_awg_id` in 4: target AWG ID, sampled when a frame is granted.
- `I_req` in 4: per-port request strobe; bit i belongs to port i+1.
- `I_delay_p1`..`I_delay_p4` in 24 each: delay values, sampled together with `I_req[i]`.
- `I_tx_ready` in 1: ready signal from `UART_TX_DATA` (high = idle, able to accept).
- `O_data` out 64: configuration word to `UART_TX_DATA`.
- `O_data_valid` out 1: frame valid.
- `O_ack` out 4: one-cycle pulse per port when its frame is accepted.
- `O_err` out 1: one-cycle pulse when a frame is abandoned on timeout.
- `O_busy` out 1: high whenever the state is not IDLE.
- `O_pending` out 4: per-port pending flags.

## Operation
- Per-port storage: a pending bit and a 24-bit delay register.
  - When `I_req[i]`=1 on a clock edge, `pending[i]` is set and `delay[i]` is loaded from `I_delay_p(i+1)`.
  - A repeated request while pending overwrites the stored delay. Requests are coalesced, so only one frame is sent.
- Frame format: `O_data` = {`HEADER`, `I_awg_id`, port number (i+1, 4 bits), `delay[i]`}. Example: AWG 14, port 2, delay 20 gives `64'h02002000_e_2_000014`.
- Arbitration is round-robin. The search starts at `last_grant`+1 modulo 4. `last_grant` resets to 3, so port 1 wins first after reset.
- State machine:
  - IDLE: if any pending bit is set, load `O_data` for the winning port, assert `O_data_valid`, record the grant, and go to SEND.
  - SEND: hold `O_data` and `O_data_valid` stable until an edge where `I_tx_ready`=1. That edge is the accept. On it:
    - deassert `O_data_valid`;
    - clear the granted port's pending bit;
    - pulse `O_ack[grant]`;
    - go to WAIT_BUSY.
  - SEND has no timeout; the block waits indefinitely for `I_tx_ready`.
  - WAIT_BUSY: wait for `I_tx_ready`=0, then go to WAIT_DONE.
    - If `TIMEOUT_CYC` cycles elapse with `I_tx_ready` still 1: pulse `O_err`, set the granted port's pending bit again (the frame is retried later with its current delay), and go to GAP.
  - WAIT_DONE: wait for `I_tx_ready`=1, then go to GAP.
  - GAP: count `GAP_CYC` cycles, then go to IDLE.
- Accept and a new request for the same port on the same edge: the set wins. The pending bit stays 1 and the new delay is stored. The frame already in flight keeps its old data.
- Requests arriving in any state are latched; only the grant happens in IDLE.

## Timing
- Reset values (asynchronous):
  - `O_data`=0, `O_data_valid`=0, `O_ack`=0, `O_err`=0, `O_busy`=0, `O_pending`=0.
  - state=IDLE, all delay registers=0, `last_grant`=3, all counters=0.
- Reset asserted mid-frame drops `O_data_valid` immediately and discards all pending requests.
- Latency from request to valid:
  - `I_req` is sampled at edge k; `O_pending` goes high after edge k.
  - `O_data_valid` goes high after edge k+1 (block idle).
- Latency from accept to ack: `O_ack` is high for exactly the one cycle following the accept edge. `O_data_valid` is low in that same cycle.
- Minimum frame-to-frame spacing: accept, then at least 1 cycle in WAIT_BUSY, 1 cycle in WAIT_DONE, `GAP_CYC` cycles in GAP, and 1 cycle in IDLE.
- `O_err` is high for the one cycle after the timeout edge.
- Counter widths: the GAP counter is 8 bits and the timeout counter is 10 bits. Both are cleared on state entry, and neither wraps.

## Test plan
- Single request: `I_req`=4'b0001, delay `24'h00000a`, `I_awg_id`=14 -> `O_data`=`64'h02002000_e_1_00000a`, valid 2 cycles after the request, `O_ack`=4'b0001 after accept, pending cleared.
- Simultaneous requests: `I_req`=4'b1111 with delays 10/20/30/40 in one cycle -> four frames in order ports 1,2,3,4 with delays `00000a`, `000014`, `00001e`, `000028`, each separated by ≥`GAP_CYC` cycles.
- Fairness: port 1 re-requests immediately after every ack while port 3 is pending -> grants alternate 1,3,1,3; port 3 is never skipped.
- Coalescing and collision:
  - port 2 requested twice (20 then 99) before its grant -> exactly one frame, delay 99;
  - a request on the accept edge -> pending stays 1 and a second frame is sent.
- Timeout: hold `I_tx_ready`=1 permanently after accept -> `O_err` pulses after 64 cycles, pending bit re-set, frame resent after the gap.
- Backpressure and reset: hold `I_tx_ready`=0 in SEND for 500 cycles -> `O_data`/valid stable; assert `I_rst_n`=0 mid-SEND -> all outputs 0 immediately, `O_pending`=0.
